// File: rtl/uart_pkg.sv
// Shared constants, register map and FSM state types for the UART peripheral.
package uart_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_DIV    = 4'hC;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_BUSY    = 4;
    localparam int ST_RX_OVF     = 5;
    localparam int ST_PARITY_ERR = 6;
    localparam int ST_FRAME_ERR  = 7;
    localparam int ST_TX_OVF     = 8;
    localparam int ST_RX_CNT     = 16;

    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int CTRL_PARITY_EN  = 2;
    localparam int CTRL_PARITY_ODD = 3;
    localparam int CTRL_RX_IRQ_EN  = 4;
    localparam int CTRL_TX_IRQ_EN  = 5;

    localparam logic [5:0] CTRL_RESET = 6'h03;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] OS_LAST    = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] OS_SAMPLE  = 4'd7;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // push/pop are one-cycle requests: push takes effect only when not full,
    // pop only when not empty, and both may take effect in the same cycle.
    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART: TX/RX FIFOs, programmable baud tick, 16x oversampled
// receiver and optional parity, all in the CPU clock domain.
module uart_fifo_periph
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0040,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          DIV_W       = 16,
    parameter int          DEFAULT_DIV = 651
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             blk_hit;
    logic [3:0]       off;
    logic             wr_data_sel, wr_status_sel, wr_ctrl_sel, wr_div_sel, rd_data_sel;
    logic [5:0]       ctrl;
    logic [DIV_W-1:0] div_reg, div_act, tick_cnt, div_wval;
    logic             tick;
    logic             tx_en, rx_en, parity_en, parity_odd, rx_irq_en, tx_irq_en;
    logic             rx_ovf, parity_err, frame_err, tx_ovf;
    logic             tx_ovf_set, rx_ovf_set, parity_set, frame_set;
    logic [31:0]      status_word;

    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]       tx_head;
    logic [CW-1:0]    tx_count;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       rx_head;
    logic [CW-1:0]    rx_count;

    tx_state_t        tx_state, tx_state_nxt;
    logic [3:0]       tx_os;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_byte;
    logic             tx_os_last, tx_can_load, tx_line, tx_busy;

    rx_state_t        rx_state, rx_state_nxt;
    logic             rx_s1, rx_s2, rx_prev, rx_fall;
    logic [3:0]       rx_os;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_byte;
    logic             rx_par_bad, rx_os_last, rx_shift, rx_par_chk;
    logic             unused_bits;

    // ---------------- bus decode ----------------
    assign blk_hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign off           = addr[3:0];
    assign wr_data_sel   = wr & blk_hit & (off == OFF_DATA);
    assign wr_status_sel = wr & blk_hit & (off == OFF_STATUS);
    assign wr_ctrl_sel   = wr & blk_hit & (off == OFF_CTRL);
    assign wr_div_sel    = wr & blk_hit & (off == OFF_DIV);
    assign rd_data_sel   = rd & blk_hit & (off == OFF_DATA);

    assign tx_en      = ctrl[CTRL_TX_EN];
    assign rx_en      = ctrl[CTRL_RX_EN];
    assign parity_en  = ctrl[CTRL_PARITY_EN];
    assign parity_odd = ctrl[CTRL_PARITY_ODD];
    assign rx_irq_en  = ctrl[CTRL_RX_IRQ_EN];
    assign tx_irq_en  = ctrl[CTRL_TX_IRQ_EN];

    assign div_wval    = wdata[DIV_W-1:0];
    assign unused_bits = ^{wdata, tx_count};

    // ---------------- FIFOs ----------------
    assign tx_push    = wr_data_sel;
    assign tx_ovf_set = wr_data_sel & tx_full;
    assign rx_pop     = rd_data_sel;
    assign rx_ovf_set = rx_push & rx_full;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .wdata (wdata[7:0]),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_byte),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl       <= CTRL_RESET;
            div_reg    <= DIV_W'(DEFAULT_DIV);
            rx_ovf     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            tx_ovf     <= 1'b0;
        end else begin
            if (wr_ctrl_sel) ctrl <= wdata[5:0];
            if (wr_div_sel)  div_reg <= (div_wval < DIV_W'(2)) ? DIV_W'(2) : div_wval;
            // Set events take priority over a same-cycle write-one-to-clear.
            rx_ovf     <= (rx_ovf & ~(wr_status_sel & wdata[ST_RX_OVF])) | rx_ovf_set;
            parity_err <= (parity_err & ~(wr_status_sel & wdata[ST_PARITY_ERR])) | parity_set;
            frame_err  <= (frame_err & ~(wr_status_sel & wdata[ST_FRAME_ERR])) | frame_set;
            tx_ovf     <= (tx_ovf & ~(wr_status_sel & wdata[ST_TX_OVF])) | tx_ovf_set;
        end
    end

    // Divisor changes are latched only at wrap so a period is never cut short.
    assign tick = (tick_cnt == div_act - DIV_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            div_act  <= DIV_W'(DEFAULT_DIV);
        end else if (tick) begin
            tick_cnt <= '0;
            div_act  <= div_reg;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        status_word                   = '0;
        status_word[ST_TX_FULL]       = tx_full;
        status_word[ST_TX_EMPTY]      = tx_empty;
        status_word[ST_RX_FULL]       = rx_full;
        status_word[ST_RX_EMPTY]      = rx_empty;
        status_word[ST_TX_BUSY]       = tx_busy;
        status_word[ST_RX_OVF]        = rx_ovf;
        status_word[ST_PARITY_ERR]    = parity_err;
        status_word[ST_FRAME_ERR]     = frame_err;
        status_word[ST_TX_OVF]        = tx_ovf;
        status_word[ST_RX_CNT +: 8]   = 8'(rx_count);
    end

    always_comb begin
        rdata = '0;
        if (rd && blk_hit) begin
            case (off)
                OFF_DATA:   rdata = {24'd0, (rx_empty ? 8'd0 : rx_head)};
                OFF_STATUS: rdata = status_word;
                OFF_CTRL:   rdata = {26'd0, ctrl};
                OFF_DIV:    rdata = 32'(div_reg);
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty & ~tx_busy)
               | rx_ovf | parity_err | frame_err | tx_ovf;

    // ---------------- TX engine ----------------
    assign tx_os_last  = (tx_os == OS_LAST);
    assign tx_can_load = tick & tx_en & ~tx_empty;
    assign tx_busy     = (tx_state != TX_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_can_load) tx_state_nxt = TX_START;
            TX_START:  if (tick && tx_os_last) tx_state_nxt = TX_DATA;
            TX_DATA:   if (tick && tx_os_last && tx_bit == 3'd7)
                           tx_state_nxt = parity_en ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tick && tx_os_last) tx_state_nxt = TX_STOP;
            TX_STOP:   if (tick && tx_os_last)
                           tx_state_nxt = tx_can_load ? TX_START : TX_IDLE;
            default:   tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop  = 1'b0;
        tx_line = 1'b1;
        case (tx_state)
            TX_IDLE:   tx_pop  = tx_can_load;
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_byte[tx_bit];
            TX_PARITY: tx_line = parity_bit(tx_byte, parity_odd);
            TX_STOP:   tx_pop  = tx_os_last & tx_can_load;
            default:   tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_tx <= 1'b1;
            tx_os   <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
        end else begin
            uart_tx <= tx_line;
            if (tx_pop) begin
                tx_byte <= tx_head;
                tx_bit  <= '0;
                tx_os   <= '0;
            end else if (tick && tx_state != TX_IDLE) begin
                tx_os <= tx_os + 4'd1;
                if (tx_state == TX_DATA && tx_os_last) tx_bit <= tx_bit + 3'd1;
            end
        end
    end

    // ---------------- RX engine ----------------
    assign rx_fall    = rx_prev & ~rx_s2;
    assign rx_os_last = (rx_os == OS_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        if (rx_state != RX_IDLE && !rx_en) begin
            rx_state_nxt = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:   if (rx_en && rx_fall) rx_state_nxt = RX_START;
                RX_START:  if (tick && rx_os == OS_SAMPLE)
                               rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:   if (tick && rx_os_last && rx_bit == 3'd7)
                               rx_state_nxt = parity_en ? RX_PARITY : RX_STOP;
                RX_PARITY: if (tick && rx_os_last) rx_state_nxt = RX_STOP;
                RX_STOP:   if (tick && rx_os_last) rx_state_nxt = RX_IDLE;
                default:   rx_state_nxt = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_shift   = 1'b0;
        rx_par_chk = 1'b0;
        rx_push    = 1'b0;
        case (rx_state)
            RX_DATA:   rx_shift   = rx_en & tick & rx_os_last;
            RX_PARITY: rx_par_chk = rx_en & tick & rx_os_last;
            RX_STOP:   rx_push    = rx_en & tick & rx_os_last;
            default:   rx_push    = 1'b0;
        endcase
    end

    // The byte is delivered even with a bad parity or stop bit; errors are flagged.
    assign frame_set  = rx_push & ~rx_s2;
    assign parity_set = rx_push & parity_en & rx_par_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_os      <= '0;
            rx_bit     <= '0;
            rx_byte    <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_state == RX_IDLE) begin
                rx_os      <= '0;
                rx_bit     <= '0;
                rx_par_bad <= 1'b0;
            end else if (tick) begin
                if (rx_state == RX_START && rx_os == OS_SAMPLE) rx_os <= '0;
                else                                            rx_os <= rx_os + 4'd1;
                if (rx_shift) begin
                    rx_byte <= {rx_s2, rx_byte[7:1]};
                    rx_bit  <= rx_bit + 3'd1;
                end
                if (rx_par_chk) rx_par_bad <= (rx_s2 != parity_bit(rx_byte, parity_odd));
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed bench for uart_fifo_periph: register map, TX waveform, loopback,
// FIFO overflow, RX glitch/frame/parity errors and mid-frame reset.
module tb_uart_fifo_periph;

    localparam logic [31:0] A_DATA   = 32'h4000_0040;
    localparam logic [31:0] A_STATUS = 32'h4000_0044;
    localparam logic [31:0] A_CTRL   = 32'h4000_0048;
    localparam logic [31:0] A_DIV    = 32'h4000_004C;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        uart_rx;
    logic        uart_tx;
    logic        irq;
    logic        rx_drv;
    logic        loopback;

    int          checks;
    int          errors;
    logic [7:0]  exp_q[$];
    logic [0:0]  bit_q[$];

    assign uart_rx = loopback ? uart_tx : rx_drv;

    uart_fifo_periph dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick_clk(1);
        wr    = 1'b0;
    endtask

    // Non-popping register read that stays between clock edges.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d    = rdata;
        rd   = 1'b0;
        #1;
    endtask

    task automatic read_data(output logic [31:0] d);
        addr = A_DATA;
        rd   = 1'b1;
        #1;
        d    = rdata;
        tick_clk(1);
        rd   = 1'b0;
    endtask

    task automatic send_and_check_tx(input logic [7:0] b, input string tag);
        logic [31:0] s;
        int          lat;
        logic [0:0]  eb;
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
        bit_q.push_back(1'b1);
        bus_write(A_DATA, {24'd0, b});
        lat = 0;
        while (uart_tx !== 1'b0 && lat < 50) begin
            tick_clk(1);
            lat++;
        end
        check({tag, "_latency_le_6"}, 32'(lat <= 6), 32'd1);
        tick_clk(32);
        for (int i = 0; i < 10; i++) begin
            eb = bit_q.pop_front();
            check($sformatf("%s_bit%0d", tag, i), {31'd0, uart_tx}, {31'd0, eb});
            if (i == 0) begin
                peek(A_STATUS, s);
                check({tag, "_busy_mid"}, {31'd0, s[4]}, 32'd1);
            end
            if (i < 9) tick_clk(64);
        end
        tick_clk(40);
        peek(A_STATUS, s);
        check({tag, "_busy_end"}, {31'd0, s[4]}, 32'd0);
        check({tag, "_tx_empty"}, {31'd0, s[1]}, 32'd1);
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic has_par,
                                  input logic par, input logic stop);
        rx_drv = 1'b0;
        tick_clk(64);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            tick_clk(64);
        end
        if (has_par) begin
            rx_drv = par;
            tick_clk(64);
        end
        rx_drv = stop;
        tick_clk(64);
        rx_drv = 1'b1;
        tick_clk(64);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] s;
        logic [31:0] d;
        logic [7:0]  v;
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        wdata    = '0;
        rx_drv   = 1'b1;
        loopback = 1'b0;
        tick_clk(5);
        reset = 1'b1;
        tick_clk(2);

        // Reset state
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        peek(A_STATUS, s); check("rst_status", s, 32'h0000_000A);
        peek(A_CTRL, s);   check("rst_ctrl", s, 32'h0000_0003);
        peek(A_DIV, s);    check("rst_div", s, 32'd651);

        // Divisor clamp and update
        bus_write(A_DIV, 32'd0);
        peek(A_DIV, s); check("div_clamp0", s, 32'd2);
        bus_write(A_DIV, 32'd4);
        peek(A_DIV, s); check("div_4", s, 32'd4);
        tick_clk(700);

        // TX waveform of 0x55
        send_and_check_tx(8'h55, "tx55");

        // Loopback with even parity
        loopback = 1'b1;
        bus_write(A_CTRL, 32'h07);
        bus_write(A_DATA, 32'hA3);
        exp_q.push_back(8'hA3);
        for (int n = 0; n < 1500; n++) begin
            peek(A_STATUS, s);
            if (s[3] == 1'b0) break;
            tick_clk(1);
        end
        check("lb_rx_not_empty", {31'd0, s[3]}, 32'd0);
        check("lb_rx_count", {24'd0, s[23:16]}, 32'd1);
        check("lb_err_flags", {29'd0, s[7:5]}, 32'd0);
        check("lb_irq_off", {31'd0, irq}, 32'd0);
        bus_write(A_CTRL, 32'h17);
        check("lb_irq_on", {31'd0, irq}, 32'd1);
        read_data(d);
        check("lb_data", d, {24'd0, exp_q.pop_front()});
        check("lb_irq_after_read", {31'd0, irq}, 32'd0);
        tick_clk(100);

        // TX overflow then drain 16 frames through loopback
        bus_write(A_CTRL, 32'h02);
        for (int i = 0; i < 17; i++) begin
            v = 8'($urandom_range(0, 255));
            bus_write(A_DATA, {24'd0, v});
            if (i < 16) exp_q.push_back(v);
        end
        peek(A_STATUS, s);
        check("ovf_tx_full", {31'd0, s[0]}, 32'd1);
        check("ovf_tx_ovf", {31'd0, s[8]}, 32'd1);
        check("ovf_irq", {31'd0, irq}, 32'd1);
        bus_write(A_STATUS, 32'h100);
        peek(A_STATUS, s);
        check("ovf_w1c", {31'd0, s[8]}, 32'd0);
        check("ovf_irq_clear", {31'd0, irq}, 32'd0);
        bus_write(A_CTRL, 32'h03);
        for (int n = 0; n < 12000; n++) begin
            peek(A_STATUS, s);
            if (s[23:16] == 8'd16) break;
            tick_clk(1);
        end
        check("drain_rx_count", {24'd0, s[23:16]}, 32'd16);
        tick_clk(800);
        peek(A_STATUS, s);
        check("drain_rx_count_final", {24'd0, s[23:16]}, 32'd16);
        check("drain_rx_full", {31'd0, s[2]}, 32'd1);
        check("drain_no_rx_ovf", {31'd0, s[5]}, 32'd0);
        check("drain_tx_idle", {30'd0, s[4], s[1]}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            read_data(d);
            check($sformatf("drain_data%0d", i), d, {24'd0, exp_q.pop_front()});
        end
        peek(A_STATUS, s);
        check("drain_rx_empty", {31'd0, s[3]}, 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        // Glitch reject
        loopback = 1'b0;
        rx_drv   = 1'b1;
        tick_clk(20);
        rx_drv = 1'b0;
        tick_clk(20);
        rx_drv = 1'b1;
        tick_clk(100);
        peek(A_STATUS, s);
        check("glitch_rx_empty", {31'd0, s[3]}, 32'd1);

        // Frame error: byte still delivered
        drive_rx_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h3C);
        peek(A_STATUS, s);
        check("ferr_rx_count", {24'd0, s[23:16]}, 32'd1);
        check("ferr_flag", {31'd0, s[7]}, 32'd1);
        check("ferr_no_perr", {31'd0, s[6]}, 32'd0);
        check("ferr_irq", {31'd0, irq}, 32'd1);
        read_data(d);
        check("ferr_data", d, {24'd0, exp_q.pop_front()});
        bus_write(A_STATUS, 32'h80);
        peek(A_STATUS, s);
        check("ferr_w1c", {31'd0, s[7]}, 32'd0);
        check("ferr_irq_clear", {31'd0, irq}, 32'd0);

        // Even parity expects 0 for 0x3C; send 1 to force a parity error
        bus_write(A_CTRL, 32'h07);
        drive_rx_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        exp_q.push_back(8'h3C);
        peek(A_STATUS, s);
        check("perr_flag", {31'd0, s[6]}, 32'd1);
        check("perr_no_ferr", {31'd0, s[7]}, 32'd0);
        read_data(d);
        check("perr_data", d, {24'd0, exp_q.pop_front()});
        bus_write(A_STATUS, 32'h40);
        peek(A_STATUS, s);
        check("perr_w1c", {31'd0, s[6]}, 32'd0);

        // Odd parity expects 1 for 0x3C
        bus_write(A_CTRL, 32'h0F);
        drive_rx_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        exp_q.push_back(8'h3C);
        peek(A_STATUS, s);
        check("odd_no_perr", {31'd0, s[6]}, 32'd0);
        check("odd_rx_count", {24'd0, s[23:16]}, 32'd1);
        read_data(d);
        check("odd_data", d, {24'd0, exp_q.pop_front()});

        // Reset in the middle of a TX frame
        bus_write(A_CTRL, 32'h03);
        bus_write(A_DATA, 32'hF0);
        tick_clk(300);
        check("pre_reset_tx_low", {31'd0, uart_tx}, 32'd0);
        reset = 1'b0;
        #1;
        check("reset_tx_high", {31'd0, uart_tx}, 32'd1);
        peek(A_STATUS, s); check("reset_status", s, 32'h0000_000A);
        peek(A_DIV, s);    check("reset_div", s, 32'd651);
        tick_clk(2);
        reset = 1'b1;
        tick_clk(2);
        peek(A_STATUS, s); check("post_reset_status", s, 32'h0000_000A);
        check("post_reset_irq", {31'd0, irq}, 32'd0);
        bus_write(A_DIV, 32'd4);
        tick_clk(700);
        send_and_check_tx(8'h96, "tx96");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
